// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial byte receiver.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int unsigned DATA_BITS            = 8;
    // 50 MHz system clock at 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial pin plus falling-edge detector.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resynchronize the pin; all flops reset to the idle-high line level
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s    = sync_q;
    assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/serial_byte_rx.sv
// 8N1 serial receiver: mid-bit sampling, stop-bit check, one-cycle valid/error strobes.
module serial_byte_rx
    import serial_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] serial_data,
    output logic                 serial_vld,
    output logic                 frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);

    logic rx_s;
    logic rx_fall;

    rx_state_t            state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 vld_q,     vld_d;
    logic                 err_q,     err_d;
    logic                 expired;

    rx_sync u_rx_sync (
        .clk     (clk),
        .rst     (rst),
        .rx      (RX),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    // Counter reaching 1 marks the sample point of the current bit
    assign expired = (cnt_q == CNT_W'(1));

    // Receiver state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
        end
    end

    // Next-state, counter, shift and strobe logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    cnt_d   = HALF_BIT;
                    state_d = START;
                end
            end
            START: begin
                if (expired) begin
                    if (!rx_s) begin
                        bit_cnt_d = '0;
                        cnt_d     = FULL_BIT;
                        state_d   = DATA;
                    end else begin
                        // line back high at mid-start: treat as a glitch
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (expired) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    cnt_d     = FULL_BIT;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (expired) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        vld_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_IDLE: begin
                // a held-low line (break) must return high before re-arming
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign serial_data = data_q;
    assign serial_vld  = vld_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx at 16 clocks per bit.
module tb_serial_byte_rx;
    import serial_rx_pkg::*;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic [7:0] serial_data;
    logic       serial_vld;
    logic       frame_err;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         both_cnt = 0;
    int         vld_cycs[$];
    logic [7:0] vld_vals[$];
    int         err_cycs[$];

    serial_byte_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .serial_data (serial_data),
        .serial_vld  (serial_vld),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe cycle away from the active edge
    always @(negedge clk) begin
        if (serial_vld) begin
            vld_cycs.push_back(cyc);
            vld_vals.push_back(serial_data);
        end
        if (frame_err) err_cycs.push_back(cyc);
        if (serial_vld && frame_err) both_cnt = both_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] vld_val_at(input int idx);
        if (vld_vals.size() > idx) return {24'h0, vld_vals[idx]};
        return 32'hdead_beef;
    endfunction

    function automatic int vld_cyc_at(input int idx);
        if (vld_cycs.size() > idx) return vld_cycs[idx];
        return -100000;
    endfunction

    function automatic int err_cyc_at(input int idx);
        if (err_cycs.size() > idx) return err_cycs[idx];
        return -100000;
    endfunction

    // Drive one frame LSB first; called and returning on a falling clock edge
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int start);
        start = cyc;
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (CPB) @(negedge clk);
        end
        RX = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    int t0;
    int t1;
    int n0;
    int e0;
    int lat;
    int c0;

    initial begin
        rst = 1'b1;
        RX  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", {24'h0, serial_data}, 32'h0);
        check("reset_vld", {31'h0, serial_vld}, 32'h0);
        check("reset_err", {31'h0, frame_err}, 32'h0);
        check("reset_state", {29'h0, dut.state_q}, {29'h0, IDLE});
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 1: single frame, pulse 1 + 8 + 144 + sync delay after the pin edge
        n0 = vld_cycs.size();
        e0 = err_cycs.size();
        send_frame(8'hA5, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("t1_vld_count", 32'(vld_cycs.size() - n0), 32'd1);
        check("t1_data", vld_val_at(n0), 32'hA5);
        lat = vld_cyc_at(n0) - t0;
        check("t1_latency_in_155_156", {31'h0, (lat == 155 || lat == 156)}, 32'd1);
        check("t1_no_err", 32'(err_cycs.size() - e0), 32'd0);
        check("t1_data_held", {24'h0, serial_data}, 32'hA5);

        // 2: back-to-back frames with a single stop bit
        n0 = vld_cycs.size();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        repeat (20) @(negedge clk);
        check("t2_vld_count", 32'(vld_cycs.size() - n0), 32'd2);
        check("t2_first", vld_val_at(n0), 32'h00);
        check("t2_second", vld_val_at(n0 + 1), 32'hFF);
        check("t2_gap", 32'(vld_cyc_at(n0 + 1) - vld_cyc_at(n0)), 32'd160);
        repeat (30) @(negedge clk);
        check("t2_hold", {24'h0, serial_data}, 32'hFF);

        // 3: 4-cycle glitch, back in IDLE within 9 cycles of detection
        n0 = vld_cycs.size();
        e0 = err_cycs.size();
        c0 = cyc;
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (8) @(negedge clk);
        check("t3_idle_after_glitch", {29'h0, dut.state_q}, {29'h0, IDLE});
        repeat (20) @(negedge clk);
        check("t3_no_vld", 32'(vld_cycs.size() - n0), 32'd0);
        check("t3_no_err", 32'(err_cycs.size() - e0), 32'd0);
        send_frame(8'h5A, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("t3_next_count", 32'(vld_cycs.size() - n0), 32'd1);
        check("t3_next_data", vld_val_at(n0), 32'h5A);

        // 4: framing error, then break, then recovery
        n0 = vld_cycs.size();
        send_frame(8'hA5, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("t4_pre_data", vld_val_at(n0), 32'hA5);
        n0 = vld_cycs.size();
        e0 = err_cycs.size();
        send_frame(8'h3C, 1'b0, t0);
        repeat (200) @(negedge clk);
        check("t4_err_count", 32'(err_cycs.size() - e0), 32'd1);
        lat = err_cyc_at(e0) - t0;
        check("t4_err_latency_in_155_156", {31'h0, (lat == 155 || lat == 156)}, 32'd1);
        check("t4_no_vld", 32'(vld_cycs.size() - n0), 32'd0);
        check("t4_data_kept", {24'h0, serial_data}, 32'hA5);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_release_quiet", 32'(err_cycs.size() - e0), 32'd1);
        send_frame(8'h81, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("t4_recover_count", 32'(vld_cycs.size() - n0), 32'd1);
        check("t4_recover_data", vld_val_at(n0), 32'h81);

        // 5: reset during data bit 3 of frame 0x0F
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            RX = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        RX = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n0 = vld_cycs.size();
        e0 = err_cycs.size();
        check("t5_data_cleared", {24'h0, serial_data}, 32'h0);
        check("t5_vld_low", {31'h0, serial_vld}, 32'h0);
        check("t5_err_low", {31'h0, frame_err}, 32'h0);
        check("t5_state_idle", {29'h0, dut.state_q}, {29'h0, IDLE});
        repeat (200) @(negedge clk);
        check("t5_no_spurious_vld", 32'(vld_cycs.size() - n0), 32'd0);
        check("t5_no_spurious_err", 32'(err_cycs.size() - e0), 32'd0);
        send_frame(8'h81, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("t5_count", 32'(vld_cycs.size() - n0), 32'd1);
        check("t5_data", vld_val_at(n0), 32'h81);

        check("vld_err_exclusive", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_byte_rx.md
# serial_byte_rx

Serial receiver for the protocol-trigger path: deserializes an asynchronous 8N1 serial line into bytes and presents each one as `serial_data` with a single-cycle `serial_vld` strobe. This is the producing end of the `serial_data`/`serial_vld` interface. It drives the protocol data-match logic and any other byte consumer. It synchronizes the pin, detects start bits, samples at mid-bit, checks the stop bit and flags framing errors.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range is ≥ 4 and even.
- `clk`  input  1  system clock. All logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `RX`  input  1  asynchronous serial line. Idles high.
- `serial_data`  output  8  last correctly framed byte, LSB received first.
- `serial_vld`  output  1  one-cycle pulse when `serial_data` is updated.
- `frame_err`  output  1  one-cycle pulse when a stop bit is sampled low.

One clock; reset is synchronous and active-high.

## Operation
- **Input synchronizer:** `RX` passes through two flops, reset to 1. A falling edge is detected when the synchronized value is 0 and its previous value is 1.
- **State machine:**
  - `IDLE`: on a falling edge, load the baud counter with `CLKS_PER_BIT/2` and go to `START`.
  - `START`: at counter expiry, sample the line.
    - Line 0: clear the bit counter, load the counter with `CLKS_PER_BIT`, go to `DATA`.
    - Line 1 (glitch or false start): go to `IDLE`. No output activity.
  - `DATA`: at each expiry, shift the sample into bit 7 of the shift register (right shift) and reload the counter. After the 8th sample, go to `STOP`.
  - `STOP`: at expiry, sample the line.
    - Line 1: `serial_data` ← shift register, pulse `serial_vld`, go to `IDLE`.
    - Line 0: pulse `frame_err`, leave `serial_data` unchanged, go to `WAIT_IDLE`.
  - `WAIT_IDLE`: wait until the synchronized line is 1, then go to `IDLE`. A line held low (break) never produces a byte.
- **Baud counter:** width `$clog2(CLKS_PER_BIT+1)`, counts down; "expiry" means it reaches 1. Bit counter: 4 bits, 0–8.
- **Exclusivity:** `serial_vld` and `frame_err` are never high in the same cycle.
- **Back-to-back frames:** a falling edge is accepted in the cycle after returning to `IDLE`. Back-to-back frames with exactly one stop bit are received without loss.
- **Reset:** reset at any time, including mid-frame, forces:
  - state `IDLE`, counters 0, shift register 0;
  - `serial_data` = 8'h00, `serial_vld` = 0, `frame_err` = 0;
  - synchronizer flops = 1.

  A partial frame in progress is discarded.

## Timing
- Cycle E is the cycle in which the falling edge is detected. E is 2–3 clocks after the pin edge because of the synchronizer.
- Sample points are relative to E:
  - start bit at E + `CLKS_PER_BIT/2`;
  - data bit k (0–7) at E + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`;
  - stop bit at E + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- `serial_vld` or `frame_err` is registered and high for exactly the one cycle after the stop sample.
- `serial_data` changes in the same cycle `serial_vld` rises, then holds until the next valid frame.
- There is no backpressure: a consumer must capture `serial_data` on `serial_vld` or use it while it is held.
- Tolerated baud mismatch is about ±4 %, given mid-bit sampling over 10 bits.

## Structure
- Package `serial_rx_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t`;
  - `localparam DATA_BITS = 8`;
  - the default `CLKS_PER_BIT` constant.
- Sub-module `rx_sync`: two-flop synchronizer plus falling-edge detector, with outputs `rx_s` and `rx_fall`. Its reset value is 1.
- Top level: FSM, baud counter, bit counter, shift register, output registers.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
1. **Single frame:** frame 0xA5 (line 1,0,1,0,0,1,0,1 LSB first, stop 1) → `serial_data` = 0xA5 and `serial_vld` high exactly 1 cycle, at E + 8 + 144 + 1; `frame_err` stays 0.
2. **Back-to-back frames:** 0x00 then 0xFF, each with one stop bit → two `serial_vld` pulses 160 cycles apart, values 0x00 then 0xFF.
3. **False start:** a 4-cycle low glitch on idle `RX` → no `serial_vld` and no `frame_err`; FSM returns to `IDLE` by E + 9. A following frame 0x5A is received correctly.
4. **Framing error and break:**
   - After 0xA5, send 0x3C with the stop bit low → `frame_err` pulses once, `serial_data` stays 0xA5, no `serial_vld`.
   - Hold `RX` low for a further 200 cycles → no further outputs.
   - Release the line, then send 0x81 → 0x81 is received.
5. **Reset mid-frame:** assert `rst` for 1 cycle during data bit 3 → next cycle all outputs are 0 and the FSM is in `IDLE`. A new frame 0x81 is received correctly, with no spurious pulse from the aborted frame.
